// File: rtl/data_memory_ls.sv
// Byte-addressed load/store data memory with a valid/ready request channel and a registered response.
// Handles byte/half/word/dword accesses, byte-lane write merge, sign/zero-extended loads and misalignment faults.
module data_memory_ls #(
    parameter int DATA_WIDTH   = 64,
    parameter int ADDR_WIDTH   = 13,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_fault
);
    localparam int NB    = DATA_WIDTH / 8;
    localparam int LB    = $clog2(NB);
    localparam int IW    = ADDR_WIDTH - LB;
    localparam int DEPTH = 2 ** IW;
    localparam int BW    = $clog2(DATA_WIDTH);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    state_t                state_q, state_d;
    logic [2:0]            cnt_q, cnt_d;
    logic                  ready_q, ready_d;
    logic                  resp_valid_q, resp_valid_d;
    logic [DATA_WIDTH-1:0] resp_rdata_q, resp_rdata_d;
    logic                  resp_fault_q, resp_fault_d;
    logic [DATA_WIDTH-1:0] pend_rdata_q, pend_rdata_d;
    logic                  pend_fault_q, pend_fault_d;

    logic                  accept;
    logic [LB-1:0]         lane;
    logic [IW-1:0]         widx;
    int                    nbits;
    logic                  fault;
    logic [DATA_WIDTH-1:0] rd_word, shifted, size_mask, load_res, merged, wr_mask;
    logic [BW-1:0]         msb_idx;
    logic                  sign;
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] acc_rdata;

    // Datapath: everything is evaluated against the current storage so a store committed
    // at an earlier edge is always seen by a later load.
    always_comb begin
        lane      = req_addr[LB-1:0];
        widx      = req_addr[ADDR_WIDTH-1:LB];
        nbits     = (8 << req_size) > DATA_WIDTH ? DATA_WIDTH : (8 << req_size);
        fault     = ((req_addr[2:0] & ((3'd1 << req_size) - 3'd1)) != 3'd0) ||
                    (req_size == 2'b11 && DATA_WIDTH == 32);
        rd_word   = mem_q[widx];
        shifted   = rd_word >> (int'(lane) * 8);
        size_mask = {DATA_WIDTH{1'b1}} >> (DATA_WIDTH - nbits);
        msb_idx   = BW'(nbits - 1);
        sign      = ~req_unsigned & shifted[msb_idx];
        load_res  = (shifted & size_mask) | (sign ? ~size_mask : '0);
        wr_mask   = size_mask << (int'(lane) * 8);
        merged    = (rd_word & ~wr_mask) | ((req_wdata << (int'(lane) * 8)) & wr_mask);
        accept    = req_valid && ready_q;
        wr_en     = accept && req_write && !fault;
        acc_rdata = (req_write || fault) ? '0 : load_res;
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = '0;
        resp_fault_d = 1'b0;
        pend_rdata_d = pend_rdata_q;
        pend_fault_d = pend_fault_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (READ_LATENCY == 1) begin
                        resp_valid_d = 1'b1;
                        resp_rdata_d = acc_rdata;
                        resp_fault_d = fault;
                    end else begin
                        state_d      = S_WAIT;
                        cnt_d        = 3'(READ_LATENCY - 1);
                        pend_rdata_d = acc_rdata;
                        pend_fault_d = fault;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 3'd1) begin
                    state_d      = S_IDLE;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = pend_rdata_q;
                    resp_fault_d = pend_fault_q;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            ready_q      <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_fault_q <= 1'b0;
            pend_rdata_q <= '0;
            pend_fault_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            ready_q      <= ready_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_fault_q <= resp_fault_d;
            pend_rdata_q <= pend_rdata_d;
            pend_fault_q <= pend_fault_d;
            if (wr_en) mem_q[widx] <= merged;
        end
    end

    assign req_ready  = ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_fault = resp_fault_q;
endmodule
